// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;
endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder slice: binary add, then +6 correction when the sum exceeds 9.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);
  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (raw > {1'b0, BCD_MAX}) begin
      // the discarded bit 4 of (raw + 6) is exactly the decimal carry
      digit = raw[3:0] + BCD_ADJ;
      cout  = 1'b1;
    end else begin
      digit = raw[3:0];
      cout  = 1'b0;
    end
  end
endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller, one digit per clock, LSD first.
// Optional input digit validity check enabled by defining BCD_INPUT_CHECK_EN.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_q, sum_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d, cout_q, cout_d, err_q, err_d;
  logic [3:0]     dig;
  logic           dig_c;
  logic           bad_in;

  bcd_digit_add u_dig (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .cin  (carry_q),
    .digit(dig),
    .cout (dig_c)
  );

`ifdef BCD_INPUT_CHECK_EN
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (a[4*i +: 4] > BCD_MAX || b[4*i +: 4] > BCD_MAX) bad_in = 1'b1;
  end
`else
  assign bad_in = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          sum_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          cout_d  = 1'b0;
          err_d   = bad_in;
          state_d = ADD;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      ADD: begin
        for (int i = 0; i < DIGITS; i++)
          if (cnt_q == CW'(i)) sum_d[4*i +: 4] = dig;
        // operands shift down so the slice always sees digit [3:0]
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        carry_d = dig_c;
        if (cnt_q == LAST) begin
          cout_d  = dig_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl (DIGITS=4): vector table + scoreboard queue + corner sequences.
module tb_bcd_serial_add_ctrl;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [4*D-1:0] a = '0, b = '0;
  logic           busy, done, cout, err;
  logic [4*D-1:0] sum;

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va, vb, es;
    logic        ec, ee;
  } vec_t;

  typedef struct {
    logic [15:0] es;
    logic        ec, ee;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

`ifdef BCD_INPUT_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // called at a negedge; start is seen by the next rising edge
  task automatic issue(input logic [15:0] va, input logic [15:0] vb,
                       input logic [15:0] es, input logic ec, input logic ee);
    exp_t e;
    e.es = es; e.ec = ec; e.ee = ee;
    q.push_back(e);
    start = 1'b1; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
  endtask

  // waits for done, checks latency, busy length, result; inj>0 pulses a stray start
  task automatic wait_done(input string nm, input int inj, input bit chk_after);
    int   lat = 0;
    int   bc  = 0;
    exp_t e;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (inj > 0) start = (k == inj);
      if (done) begin lat = k; break; end
      if (busy) bc++;
    end
    start = 1'b0;
    chk({nm, " latency"}, lat, 5);
    chk({nm, " busy_cycles"}, bc, 4);
    if (q.size() == 0) begin
      chk({nm, " scoreboard_empty"}, 1, 0);
    end else begin
      e = q.pop_front();
      if (lat != 0) begin
        chk({nm, " sum"}, sum, e.es);
        chk({nm, " cout"}, cout, e.ec);
        chk({nm, " err"}, err, e.ee);
      end
    end
    if (chk_after) begin
      @(negedge clk);
      chk({nm, " done_one_cycle"}, done, 0);
      chk({nm, " idle_after"}, busy, 0);
    end
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0};
    tbl[1] = '{16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    tbl[3] = '{16'h0005, 16'h0005, 16'h0010, 1'b0, 1'b0};
    tbl[4] = '{16'h5678, 16'h4322, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[6] = '{16'h4567, 16'h1111, 16'h5678, 1'b0, 1'b0};
    tbl[7] = '{16'h00A0, 16'h0000, 16'h0100, 1'b0, ERR_EXP};

    // reset state
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
    chk("rst err", err, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].va, tbl[i].vb, tbl[i].es, tbl[i].ec, tbl[i].ee);
      wait_done($sformatf("vec%0d", i), 0, 1'b1);
    end

    // back-to-back: second start taken in the DONE cycle
    issue(16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);
    wait_done("b2b_first", 0, 1'b0);
    issue(16'h0005, 16'h0005, 16'h0010, 1'b0, 1'b0);
    wait_done("b2b_second", 0, 1'b1);

    // stray start during ADD must be ignored
    issue(16'h2468, 16'h1357, 16'h3825, 1'b0, 1'b0);
    wait_done("start_in_add", 2, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_extra_done", done, 0);
    end

    // reset mid-operation discards the partial result
    issue(16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0);
    void'(q.pop_back());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst sum", sum, 0);
    chk("midrst cout", cout, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("midrst no_done", {busy, done}, 0);
    end

    // recovery after reset
    issue(16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0);
    wait_done("post_reset", 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
